// File: rtl/fifo_stream_reader.sv
// Read-side adapter: pops a 1-cycle-latency FIFO into a valid/ready stream through a 2-entry skid buffer, framing fixed-length packets.
// Optional build macro FIFO_RD_PARITY_EN adds an even-parity output (m_parity) stored with each buffered word.
module fifo_stream_reader #(
  parameter int DATA_W  = 8,
  parameter int PKT_LEN = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              fifo_empty,
  output logic              fifo_rd,
  input  logic [DATA_W-1:0] fifo_rdata,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
`ifdef FIFO_RD_PARITY_EN
  output logic              m_parity,
`endif
  output logic              busy
);

  localparam int BEAT_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(PKT_LEN - 1);

  if (PKT_LEN < 1 || PKT_LEN > 256) begin : g_pkt_len_check
    $error("fifo_stream_reader: PKT_LEN must be in 1..256");
  end

  logic [1:0]        buf_cnt;
  logic              inflight;
  logic [BEAT_W-1:0] beat;
  logic [DATA_W-1:0] data_q [2];
`ifdef FIFO_RD_PARITY_EN
  logic              par_q  [2];
`endif

  logic       pop;
  logic       capture;
  logic       tail_idx;
  logic [2:0] occupancy;

  assign pop     = m_valid & m_ready;
  assign capture = inflight;

  // Slots committed after this edge: stored words plus the word in flight, minus the one leaving.
  assign occupancy = {1'b0, buf_cnt} + {2'b00, inflight} - {2'b00, pop};
  assign fifo_rd   = enable & ~fifo_empty & ~reset & (occupancy < 3'd2);

  // Tail slot after any pop-induced shift of entry 1 into entry 0.
  assign tail_idx = (buf_cnt == 2'd2) || ((buf_cnt == 2'd1) && !pop);

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of statement order inside the block.
  always_ff @(posedge clk) begin
    if (reset) begin
      inflight <= 1'b0;
      buf_cnt  <= 2'd0;
      beat     <= '0;
    end else begin
      inflight <= fifo_rd;
      case ({capture, pop})
        2'b10:   buf_cnt <= buf_cnt + 2'd1;
        2'b01:   buf_cnt <= buf_cnt - 2'd1;
        default: buf_cnt <= buf_cnt;
      endcase
      if (pop) beat <= (beat == LAST_BEAT) ? '0 : beat + 1'b1;
    end
  end

  // NOTE: the buffer storage is reset too, because its head drives m_data and that
  // output must read zero during reset; a plain RAM-style array would not need it.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q[0] <= '0;
      data_q[1] <= '0;
    end else begin
      if (pop)     data_q[0]        <= data_q[1];
      if (capture) data_q[tail_idx] <= fifo_rdata;
    end
  end

`ifdef FIFO_RD_PARITY_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      par_q[0] <= 1'b0;
      par_q[1] <= 1'b0;
    end else begin
      if (pop)     par_q[0]        <= par_q[1];
      if (capture) par_q[tail_idx] <= ^fifo_rdata;
    end
  end

  assign m_parity = par_q[0];
`endif

  assign m_valid = (buf_cnt != 2'd0);
  assign m_data  = data_q[0];
  assign m_last  = m_valid & (beat == LAST_BEAT);
  assign busy    = inflight | (buf_cnt != 2'd0);

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: a bench-side FIFO model feeds the DUT, a scoreboard queue checks delivered
// words and packet framing, a vector table checks cycle-exact backpressure, and short sequences cover corners.
`timescale 1ns/1ps
module tb_fifo_stream_reader;

  localparam int DATA_W  = 8;
  localparam int PKT_LEN = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              enable;
  logic              fifo_empty;
  logic              fifo_rd;
  logic [DATA_W-1:0] fifo_rdata;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_last;
  logic              busy;
`ifdef FIFO_RD_PARITY_EN
  logic              m_parity;
`endif

  always #5 clk = ~clk;

  fifo_stream_reader #(.DATA_W(DATA_W), .PKT_LEN(PKT_LEN)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .fifo_empty (fifo_empty),
    .fifo_rd    (fifo_rd),
    .fifo_rdata (fifo_rdata),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last),
`ifdef FIFO_RD_PARITY_EN
    .m_parity   (m_parity),
`endif
    .busy       (busy)
  );

  typedef struct {
    logic       ready;
    logic       rd;
    logic       valid;
    logic       bsy;
    logic [7:0] data;
    logic       last;
  } vec_t;

  vec_t vec [14];

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] model_q [$];
  logic [7:0] exp_q   [$];
  int         exp_beat = 0;
  int         cycle    = 0;
  int         n_pop, first_pop, last_pop, n_last;
  logic [7:0] last_word;
  logic       force_empty = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic update_empty();
    fifo_empty = force_empty || (model_q.size() == 0);
  endtask

  task automatic load(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) model_q.push_back(first + 8'(i));
    update_empty();
  endtask

  task automatic clear_stats();
    n_pop = 0; first_pop = 0; last_pop = 0; n_last = 0; last_word = 8'h00;
  endtask

  // Called at a falling edge with inputs already set; returns at the next falling edge.
  task automatic tick();
    logic       rd_seen;
    logic [7:0] w;
    #1;
    if (reset === 1'b0) check("buf_cnt_le2", 32'(dut.buf_cnt <= 2'd2), 1);
    if (m_valid === 1'b1 && m_ready === 1'b1 && reset === 1'b0) begin
      check("sb_word_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        w = exp_q.pop_front();
        check("sb_data", m_data, w);
        check("sb_last", m_last, 32'(exp_beat == PKT_LEN - 1));
`ifdef FIFO_RD_PARITY_EN
        check("sb_parity", m_parity, ^w);
`endif
        exp_beat = (exp_beat == PKT_LEN - 1) ? 0 : exp_beat + 1;
      end
      n_pop++;
      if (n_pop == 1) first_pop = cycle;
      last_pop = cycle;
      if (m_last) begin n_last++; last_word = m_data; end
    end
    rd_seen = fifo_rd;
    @(posedge clk);
    cycle++;
    #1;
    if (rd_seen === 1'b1) begin
      check("rd_model_nonempty", 32'(model_q.size() != 0), 1);
      if (model_q.size() != 0) begin
        fifo_rdata = model_q.pop_front();
        exp_q.push_back(fifo_rdata);
      end
    end
    update_empty();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    exp_q.delete();
    exp_beat = 0;
    reset = 1'b0;
  endtask

  task automatic drain(input int max);
    int n = 0;
    while ((model_q.size() != 0 || exp_q.size() != 0 || busy !== 1'b0) && n < max) begin
      tick();
      n++;
    end
    check("drain_in_time", 32'(n < max), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // ready, fifo_rd, m_valid, busy, m_data, m_last  (cycle 0 = first cycle after reset release)
    vec[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0};
    vec[1]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0};
    vec[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 8'hA0, 1'b0};
    vec[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 8'hA0, 1'b0};
    vec[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 8'hA0, 1'b0};
    vec[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 8'hA0, 1'b0};
    vec[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 8'hA0, 1'b0};
    vec[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'hA0, 1'b0};
    vec[8]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'hA1, 1'b0};
    vec[9]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'hA2, 1'b0};
    vec[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'hA3, 1'b1};
    vec[11] = '{1'b1, 1'b0, 1'b1, 1'b1, 8'hA4, 1'b0};
    vec[12] = '{1'b1, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0};
    vec[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};

    reset      = 1'b1;
    enable     = 1'b1;
    m_ready    = 1'b0;
    fifo_rdata = 8'h00;
    clear_stats();
    load(8'hA0, 6);
    @(negedge clk);

    // Reset with a non-empty FIFO and enable high: no reads, everything idle.
    tick();
    tick();
    #1;
    check("rst_fifo_rd", fifo_rd, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_busy",    busy,    0);
    check("rst_m_data",  m_data,  0);
    check("rst_m_last",  m_last,  0);
    reset = 1'b0;
    exp_q.delete();
    exp_beat = 0;

    // Backpressure: buffer fills to two, head holds, then all six words arrive in order.
    for (int i = 0; i < 14; i++) begin
      m_ready = vec[i].ready;
      #1;
      check($sformatf("bp_fifo_rd[%0d]", i), fifo_rd, vec[i].rd);
      check($sformatf("bp_m_valid[%0d]", i), m_valid, vec[i].valid);
      check($sformatf("bp_busy[%0d]", i),    busy,    vec[i].bsy);
      check($sformatf("bp_m_last[%0d]", i),  m_last,  vec[i].last);
      if (vec[i].valid) check($sformatf("bp_m_data[%0d]", i), m_data, vec[i].data);
      tick();
    end
    check("bp_all_delivered", exp_q.size(), 0);
    check("bp_pop_count", n_pop, 6);

    // Sustained stream: eight back-to-back beats, two packets.
    do_reset();
    clear_stats();
    m_ready = 1'b1;
    load(8'h11, 8);
    drain(40);
    check("burst_pop_count", n_pop, 8);
    check("burst_back_to_back", last_pop - first_pop, 7);
    check("burst_last_count", n_last, 2);
    check("burst_last_word", last_word, 8'h18);

    // Permanently empty FIFO: nothing happens.
    do_reset();
    force_empty = 1'b1;
    update_empty();
    for (int i = 0; i < 8; i++) begin
      #1;
      check("empty_fifo_rd", fifo_rd, 0);
      check("empty_m_valid", m_valid, 0);
      check("empty_busy",    busy,    0);
      tick();
    end
    force_empty = 1'b0;
    update_empty();

    // enable drops with one word in flight; resume keeps the packet position.
    do_reset();
    clear_stats();
    load(8'h5A, 4);
    #1;
    check("en_first_rd", fifo_rd, 1);
    tick();
    enable = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      check("en_off_no_rd", fifo_rd, 0);
      tick();
    end
    check("en_off_delivered", n_pop, 1);
    check("en_off_fifo_left", model_q.size(), 3);
    check("en_off_idle", busy, 0);
    enable = 1'b1;
    drain(30);
    check("en_resume_pops", n_pop, 4);
    check("en_resume_last_count", n_last, 1);
    check("en_resume_last_word", last_word, 8'h5D);

    // Reset while the buffer is full: contents dropped, packet counting restarts.
    do_reset();
    clear_stats();
    m_ready = 1'b0;
    load(8'h61, 6);
    for (int i = 0; i < 4; i++) tick();
    #1;
    check("full_buf_cnt", dut.buf_cnt, 2);
    check("full_no_rd", fifo_rd, 0);
    check("full_m_valid", m_valid, 1);
    reset = 1'b1;
    tick();
    exp_q.delete();
    exp_beat = 0;
    reset = 1'b0;
    #1;
    check("midrst_m_valid", m_valid, 0);
    check("midrst_busy", busy, 0);
    m_ready = 1'b1;
    drain(30);
    check("midrst_pops", n_pop, 4);
    check("midrst_last_count", n_last, 1);
    check("midrst_last_word", last_word, 8'h66);

`ifdef FIFO_RD_PARITY_EN
    // Parity follows the head word.
    do_reset();
    m_ready = 1'b0;
    model_q.push_back(8'h07);
    model_q.push_back(8'h03);
    update_empty();
    tick();
    tick();
    #1;
    check("par_head_data", m_data, 8'h07);
    check("par_07", m_parity, 1);
    m_ready = 1'b1;
    tick();
    #1;
    check("par_next_data", m_data, 8'h03);
    check("par_03", m_parity, 0);
    drain(20);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
